norm_shift_encoder: RTL and testbench



---
 rtl/norm_shift_pkg.sv | 14 +
 rtl/norm_shift_encoder_lzc_seg8.sv | 17 +
 rtl/norm_shift_encoder.sv | 172 +++++++++++++++++
 tb/tb_norm_shift_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/norm_shift_pkg.sv
// Shared constants and helpers for the normalization shift encoder.
package norm_shift_pkg;

  localparam int unsigned SEG_W = 8;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Segments covering the SWR-1 non-carry bits, last one padded at the LSB end.
  function automatic int unsigned seg_count(input int unsigned swr);
    return (swr - 1 + SEG_W - 1) / SEG_W;
  endfunction

endpackage

// File: rtl/norm_shift_encoder_lzc_seg8.sv
// 8-bit leading-zero counter with all-zero flag (combinational).
module lzc_seg8 (
  input  logic [7:0] seg_i,
  output logic [2:0] lzc_o,
  output logic       zero_o
);

  always_comb begin
    lzc_o  = '0;
    zero_o = (seg_i == '0);
    // Ascending scan: the highest set bit is the last to write lzc_o.
    for (int unsigned i = 0; i < 8; i++) begin
      if (seg_i[i]) lzc_o = 3'(7 - i);
    end
  end

endmodule

// File: rtl/norm_shift_encoder.sv
// Two-stage normalization shift encoder with valid/ready on both sides.
// Optional NORM_SHIFT_PASSTHRU_EN adds Data_o carried alongside the control outputs.
module norm_shift_encoder
  import norm_shift_pkg::*;
#(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [SWR-1:0] Data_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           FSM_left_right_o,
  output logic           zero_o
`ifdef NORM_SHIFT_PASSTHRU_EN
  ,
  output logic [SWR-1:0] Data_o
`endif
);

  localparam int unsigned NSEG  = seg_count(SWR);
  localparam int unsigned PAD_W = NSEG * SEG_W;

  if ((2 ** EWR) <= (SWR - 2)) begin : g_bad_params
    $error("norm_shift_encoder: EWR too narrow for SWR");
  end

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic valid_o_q, valid_o_d;
  logic s2_load, s1_adv, s1_load, accept;

  always_comb begin
    s2_load = !valid_o_q || ready_i;
    s1_adv  = s1_valid_q && s2_load;
    s1_load = !s1_valid_q || s1_adv;
    accept  = valid_i && s1_load;
  end

  assign ready_o = s1_load;

  // Stage 1: per-segment LZC
  logic [PAD_W-1:0]         padded;
  logic [NSEG-1:0][2:0]     seg_lzc;
  logic [NSEG-1:0]          seg_zero;
  logic [NSEG-1:0][2:0]     s1_lzc_q, s1_lzc_d;
  logic [NSEG-1:0]          s1_zero_q, s1_zero_d;
  logic                     s1_carry_q, s1_carry_d;

  always_comb begin
    padded = PAD_W'(Data_i[SWR-2:0]) << (PAD_W - (SWR - 1));
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    lzc_seg8 u_lzc (
      .seg_i  (padded[PAD_W-1-g*SEG_W -: SEG_W]),
      .lzc_o  (seg_lzc[g]),
      .zero_o (seg_zero[g])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lzc_d   = s1_lzc_q;
    s1_zero_d  = s1_zero_q;
    s1_carry_d = s1_carry_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_lzc_d   = seg_lzc;
      s1_zero_d  = seg_zero;
      s1_carry_d = Data_i[SWR-1];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: priority select of first non-zero segment
  logic [EWR-1:0] shift_q, shift_d, enc_shift;
  logic           dir_q, dir_d;
  logic           zero_q, zero_d;
  logic           found;

  always_comb begin
    found     = 1'b0;
    enc_shift = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (!found && !s1_zero_q[i]) begin
        found     = 1'b1;
        enc_shift = EWR'(i * SEG_W + 32'(s1_lzc_q[i]));
      end
    end
  end

  always_comb begin
    valid_o_d = valid_o_q;
    shift_d   = shift_q;
    dir_d     = dir_q;
    zero_d    = zero_q;
    if (s2_load) begin
      valid_o_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_carry_q) begin
          shift_d = EWR'(1);
          dir_d   = DIR_RIGHT;
          zero_d  = 1'b0;
        end else if (&s1_zero_q) begin
          shift_d = '0;
          dir_d   = DIR_LEFT;
          zero_d  = 1'b1;
        end else begin
          shift_d = enc_shift;
          dir_d   = DIR_LEFT;
          zero_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lzc_q   <= '0;
      s1_zero_q  <= '0;
      s1_carry_q <= 1'b0;
      valid_o_q  <= 1'b0;
      shift_q    <= '0;
      dir_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lzc_q   <= s1_lzc_d;
      s1_zero_q  <= s1_zero_d;
      s1_carry_q <= s1_carry_d;
      valid_o_q  <= valid_o_d;
      shift_q    <= shift_d;
      dir_q      <= dir_d;
      zero_q     <= zero_d;
    end
  end

  assign valid_o          = valid_o_q;
  assign Shift_Value_o    = shift_q;
  assign FSM_left_right_o = dir_q;
  assign zero_o           = zero_q;

`ifdef NORM_SHIFT_PASSTHRU_EN
  logic [SWR-1:0] s1_data_q, s1_data_d;
  logic [SWR-1:0] s2_data_q, s2_data_d;

  always_comb begin
    s1_data_d = accept ? Data_i : s1_data_q;
    s2_data_d = s1_adv ? s1_data_q : s2_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q <= '0;
      s2_data_q <= '0;
    end else begin
      s1_data_q <= s1_data_d;
      s2_data_q <= s2_data_d;
    end
  end

  assign Data_o = s2_data_q;
`endif

endmodule

// File: tb/tb_norm_shift_encoder.sv
// Directed + random scoreboard bench for norm_shift_encoder (SWR=26, EWR=5).
module tb_norm_shift_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i;
  logic [25:0] Data_i;
  logic        ready_o, valid_o, FSM_left_right_o, zero_o;
  logic [4:0]  Shift_Value_o;
`ifdef NORM_SHIFT_PASSTHRU_EN
  logic [25:0] Data_o;
`endif

  norm_shift_encoder #(.SWR(26), .EWR(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .Data_i           (Data_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .Shift_Value_o    (Shift_Value_o),
    .FSM_left_right_o (FSM_left_right_o),
    .zero_o           (zero_o)
`ifdef NORM_SHIFT_PASSTHRU_EN
    ,
    .Data_o           (Data_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  shift;
    logic        dir;
    logic        zero;
    logic [25:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   checks   = 0;
  int   failures = 0;
  bit   acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int shift, input logic dir, input logic zero);
    exp_t e;
    e.shift = 5'(shift);
    e.dir   = dir;
    e.zero  = zero;
    e.data  = '0;
    return e;
  endfunction

  function automatic exp_t model(input logic [25:0] d);
    exp_t e;
    e = mk(0, 1'b1, 1'b0);
    e.data = d;
    if (d[25]) begin
      e.shift = 5'd1;
      e.dir   = 1'b0;
    end else if (d == '0) begin
      e.zero = 1'b1;
    end else begin
      for (int i = 0; i <= 24; i++) begin
        if (d[i]) e.shift = 5'(24 - i);
      end
    end
    return e;
  endfunction

  // One clock: settle, score output/input transfers, advance to #1 after the edge.
  task automatic cycle(output bit accepted);
    exp_t e;
    #1;
    accepted = valid_i && ready_o;
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_valid_o", 32'(valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("shift_value", 32'(Shift_Value_o), 32'(e.shift));
        check("left_right", 32'(FSM_left_right_o), 32'(e.dir));
        check("zero", 32'(zero_o), 32'(e.zero));
`ifdef NORM_SHIFT_PASSTHRU_EN
        check("data_o", 32'(Data_o), 32'(e.data));
`endif
      end
    end
    if (accepted) sb.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [25:0] d, input exp_t e);
    bit a;
    a       = 1'b0;
    valid_i = 1'b1;
    Data_i  = d;
    pend    = e;
    pend.data = d;
    for (int n = 0; n < 50 && !a; n++) cycle(a);
    check("accept_timeout", 32'(a), 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    bit a;
    valid_i = 1'b0;
    for (int n = 0; n < 100 && sb.size() > 0; n++) cycle(a);
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [25:0] r;
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    Data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_shift", 32'(Shift_Value_o), 32'd0);
    check("rst_dir", 32'(FSM_left_right_o), 32'd0);
    check("rst_zero", 32'(zero_o), 32'd0);
    rst = 1'b0;
    cycle(acc);

    // Carry set: right shift by one; also checks the two-register latency
    send(26'h2000000, mk(1, 1'b0, 1'b0));
    check("latency_first_edge", 32'(valid_o), 32'd0);
    cycle(acc);
    check("latency_second_edge", 32'(valid_o), 32'd1);
    drain();

    send(26'h1000000, mk(0, 1'b1, 1'b0));
    send(26'h0000001, mk(24, 1'b1, 1'b0));
    drain();
    send(26'h0000000, mk(0, 1'b1, 1'b1));
    drain();

    // Backpressure: two accepts fill both stages, then ready_o drops
    ready_i = 1'b0;
    send(26'h0800000, mk(1, 1'b1, 1'b0));
    send(26'h0010000, mk(8, 1'b1, 1'b0));
    valid_i = 1'b1;
    Data_i  = 26'h0000100;
    pend    = mk(16, 1'b1, 1'b0);
    pend.data = Data_i;
    for (int n = 0; n < 2; n++) begin
      cycle(acc);
      check("bp_no_accept", 32'(acc), 32'd0);
      check("bp_ready_o", 32'(ready_o), 32'd0);
      check("bp_valid_held", 32'(valid_o), 32'd1);
      check("bp_shift_held", 32'(Shift_Value_o), 32'd1);
    end
    ready_i = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) cycle(acc);
    check("bp_third_accept", 32'(acc), 32'd1);
    drain();

    // Reset with two items in flight
    ready_i = 1'b0;
    send(26'h0000400, mk(14, 1'b1, 1'b0));
    send(26'h0000040, mk(18, 1'b1, 1'b0));
    rst = 1'b1;
    #1;
    check("rst_mid_valid_o", 32'(valid_o), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cycle(acc);
      check("post_rst_quiet", 32'(valid_o), 32'd0);
    end
    send(26'h0000080, mk(17, 1'b1, 1'b0));
    drain();

    // Random stream under random ready_i
    valid_i = 1'b0;
    acc     = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!valid_i || acc) begin
        r       = 26'($urandom);
        r       = r >> $urandom_range(0, 26);
        valid_i = ($urandom_range(0, 3) != 0);
        Data_i  = r;
        pend    = model(r);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    ready_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
